// File: rtl/instruction_fetch.sv
// Fetch stage: PC, instruction-memory reads and a valid/ready instruction register toward decode.
// FETCH_PIPE_EN selects a pipelined fetch with a 2-entry output queue; states IDLE|ISSUE|WAIT|HOLD otherwise.
module instruction_fetch #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_rd_en,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] instr,
  output logic [ADDR_SIZE-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect_en,
  input  logic [ADDR_SIZE-1:0] redirect_addr,
  input  logic                 halt
);

  logic [ADDR_SIZE-1:0] pc;
  logic                 transfer;

  assign transfer = instr_valid && instr_ready;

`ifdef FETCH_PIPE_EN

  logic                 started;
  logic                 pend;
  logic [ADDR_SIZE-1:0] pend_pc;
  logic [1:0]           occ;
  logic [1:0]           load;
  logic [1:0]           slot;
  logic [WORD_SIZE-1:0] q_data [2];
  logic [ADDR_SIZE-1:0] q_pc   [2];

  // load counts queued plus returning entries after this edge's dequeue
  assign load        = occ + {1'b0, pend} - {1'b0, transfer};
  assign slot        = occ - {1'b0, transfer};
  assign mem_rd_en   = started && !halt && !redirect_en && (load < 2'd2);
  assign mem_addr    = pc;
  assign instr_valid = (occ != 2'd0);
  assign instr       = q_data[0];
  assign instr_pc    = q_pc[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started   <= 1'b0;
      pc        <= RESET_PC;
      pend      <= 1'b0;
      pend_pc   <= '0;
      occ       <= 2'd0;
      q_data[0] <= '0;
      q_data[1] <= '0;
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
    end else begin
      started <= 1'b1;
      if (redirect_en) begin
        pc   <= redirect_addr;
        pend <= 1'b0;
        occ  <= 2'd0;
      end else begin
        pend <= mem_rd_en;
        if (mem_rd_en) begin
          pend_pc <= pc;
          pc      <= pc + ADDR_SIZE'(1);
        end
        occ <= load;
        if (transfer) begin
          q_data[0] <= q_data[1];
          q_pc[0]   <= q_pc[1];
        end
        if (pend) begin
          if (slot == 2'd0) begin
            q_data[0] <= mem_rdata;
            q_pc[0]   <= pend_pc;
          end else begin
            q_data[1] <= mem_rdata;
            q_pc[1]   <= pend_pc;
          end
        end
      end
    end
  end

`else

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t state;
  logic   in_flight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      mem_rd_en   <= 1'b0;
      mem_addr    <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      in_flight   <= 1'b0;
    end else if (redirect_en) begin
      // dropping in_flight and leaving WAIT discards whatever read is outstanding
      pc          <= redirect_addr;
      instr_valid <= 1'b0;
      in_flight   <= 1'b0;
      state       <= ISSUE;
      mem_rd_en   <= !halt;
      mem_addr    <= redirect_addr;
    end else begin
      case (state)
        IDLE: begin
          if (!halt) begin
            state     <= ISSUE;
            mem_rd_en <= 1'b1;
            mem_addr  <= pc;
          end
        end
        ISSUE: begin
          if (mem_rd_en) begin
            mem_rd_en <= 1'b0;
            pc        <= pc + ADDR_SIZE'(1);
            in_flight <= 1'b1;
            state     <= WAIT;
          end else if (!halt) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= pc;
          end
        end
        WAIT: begin
          if (in_flight) begin
            instr       <= mem_rdata;
            instr_pc    <= mem_addr;
            instr_valid <= 1'b1;
          end
          in_flight <= 1'b0;
          state     <= HOLD;
        end
        HOLD: begin
          if (transfer || !instr_valid) begin
            instr_valid <= 1'b0;
            state       <= ISSUE;
            mem_rd_en   <= !halt;
            mem_addr    <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule
